// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
//
// Purpose: bundles the requester-side handshake and the serial output of the
//          UART transmit scheduler into one port.
//
// Handshake (valid/ready style, one rule for both requesters):
//   req[i] is a level request held by requester i until it sees gnt[i].
//   gnt[i] is a one-cycle pulse that means data<i> was latched. The requester
//   may drop req[i] or change data<i> from the cycle after the pulse.
//   A req[i] that drops before its gnt[i] is simply never served.
//   done[i] pulses for one cycle when requester i's stop bit has completed.
//
// Signals:
//   req       2       requests, driven by the producers
//   data0/1   DATA_W  bytes for requester 0 / 1
//   gnt       2       one-hot grant pulse
//   done      2       one-hot frame-complete pulse
//   busy      1       scheduler not idle
//   tx        1       serial line, idle high
//   tick16    1       16x oversample clock-enable pulse
//   state_dbg 2       FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//   rr_dbg    1       round-robin pointer (preferred requester)
//
// Modports: master = byte producers, slave = the scheduler.
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
   parameter int DATA_W = 8
);
   logic [1:0]        req;
   logic [DATA_W-1:0] data0;
   logic [DATA_W-1:0] data1;
   logic [1:0]        gnt;
   logic [1:0]        done;
   logic              busy;
   logic              tx;
   logic              tick16;
   logic [1:0]        state_dbg;
   logic              rr_dbg;

   modport master (
      output req, data0, data1,
      input  gnt, done, busy, tx, tick16, state_dbg, rr_dbg
   );

   modport slave (
      input  req, data0, data1,
      output gnt, done, busy, tx, tick16, state_dbg, rr_dbg
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Purpose: shares one 8N1 serial TX line between two byte requesters using
//          round-robin arbitration. A 16x oversample tick is derived from
//          CLOCK_50 as a clock-enable; start, data (LSB first) and stop bits
//          each last OVERSAMPLE ticks.
//
// Ports:
//   CLOCK_50  in   system clock, all logic on the rising edge
//   reset_n   in   asynchronous, active-low reset
//   bus       slave modport of uart_tx_scheduler_if (req/data in,
//             gnt/done/busy/tx/tick16 and debug state out)
//
// Parameters:
//   TICK_DIV    clock cycles per 16x tick (326 for 9600 bps from 50 MHz)
//   OVERSAMPLE  ticks per bit period
//   DATA_W      data bits per frame
//
// tx, gnt and done are flops; nothing on them depends combinationally on req.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int TICK_DIV   = 326,
   parameter int OVERSAMPLE = 16,
   parameter int DATA_W     = 8
) (
   input  logic                 CLOCK_50,
   input  logic                 reset_n,
   uart_tx_scheduler_if.slave   bus
);

   // Counter widths, kept at least one bit wide for degenerate parameters.
   localparam int TCNT_W = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
   localparam int SCNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BCNT_W = (DATA_W     > 1) ? $clog2(DATA_W)     : 1;

   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TICK_DIV - 1);
   localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(OVERSAMPLE - 1);
   localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [TCNT_W-1:0]   tcnt_q,  tcnt_d;
   logic [SCNT_W-1:0]   scnt_q,  scnt_d;
   logic [BCNT_W-1:0]   bcnt_q,  bcnt_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                rr_q,    rr_d;     // preferred requester
   logic                id_q,    id_d;     // owner of the frame in flight
   logic [1:0]          gnt_q,   gnt_d;
   logic [1:0]          done_q,  done_d;
   logic                tx_q,    tx_d;

   logic                tick;
   logic                bit_end;
   logic                winner;

   // ---------------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      scnt_d  = scnt_q;
      bcnt_d  = bcnt_q;
      shift_d = shift_q;
      rr_d    = rr_q;
      id_d    = id_q;
      gnt_d   = 2'b00;
      done_d  = 2'b00;
      tx_d    = 1'b1;
      winner  = 1'b0;

      // Free-running tick divider; keeps running in IDLE so tick16 can be
      // reused by a receiver.
      tick    = (tcnt_q == TCNT_MAX);
      tcnt_d  = tick ? '0 : tcnt_q + TCNT_W'(1);

      // A bit period ends on the tick that completes OVERSAMPLE ticks.
      bit_end = tick && (scnt_q == SCNT_MAX);

      if (state_q != IDLE && tick) begin
         scnt_d = bit_end ? '0 : scnt_q + SCNT_W'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (bus.req != 2'b00) begin
               // Single requester wins outright; on contention rr decides.
               if (bus.req == 2'b01) begin
                  winner = 1'b0;
               end else if (bus.req == 2'b10) begin
                  winner = 1'b1;
               end else begin
                  winner = rr_q;
               end
               state_d = START;
               // Restart the divider so bit boundaries line up with the
               // start of the frame regardless of the tick phase.
               tcnt_d  = '0;
               scnt_d  = '0;
               bcnt_d  = '0;
               shift_d = winner ? bus.data1 : bus.data0;
               rr_d    = ~winner;
               id_d    = winner;
               gnt_d   = winner ? 2'b10 : 2'b01;
            end
         end

         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bcnt_q == BCNT_MAX) begin
                  state_d = STOP;
                  bcnt_d  = '0;
               end else begin
                  bcnt_d  = bcnt_q + BCNT_W'(1);
               end
            end
         end

         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               done_d  = id_q ? 2'b10 : 2'b01;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // tx is registered: it is decoded from the state being entered so the
      // line changes on the same edge as the state.
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         tcnt_q  <= '0;
         scnt_q  <= '0;
         bcnt_q  <= '0;
         shift_q <= '0;
         rr_q    <= 1'b0;
         id_q    <= 1'b0;
         gnt_q   <= 2'b00;
         done_q  <= 2'b00;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         scnt_q  <= scnt_d;
         bcnt_q  <= bcnt_d;
         shift_q <= shift_d;
         rr_q    <= rr_d;
         id_q    <= id_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         tx_q    <= tx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.gnt       = gnt_q;
   assign bus.done      = done_q;
   assign bus.tx        = tx_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.tick16    = tick;
   assign bus.state_dbg = state_q;
   assign bus.rr_dbg    = rr_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Serial transmit scheduler for the UART path. It shares one 9600 bps 8N1 TX line between two byte requesters using round-robin arbitration. It derives the 16x oversample tick internally from CLOCK_50 as a clock-enable rather than a generated clock, and sequences start, data and stop bits on that tick. It sits between the lab's byte producers (e.g. keyboard/ROM senders) and the `tx` pin.

## Interface
- `TICK_DIV`, 326: CLOCK_50 cycles per 16x tick (50 MHz / (16·9600) ≈ 325.5, rounded).
- `OVERSAMPLE`, 16: ticks per bit period.
- `DATA_W`, 8: data bits per frame.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz, all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-requester send request; level, held until the matching `gnt`.
- `data0`  in  DATA_W  byte for requester 0; sampled on the grant edge.
- `data1`  in  DATA_W  byte for requester 1; sampled on the grant edge.
- `gnt`  out  2  one-hot, one-cycle pulse: that requester's byte was latched.
- `done`  out  2  one-hot, one-cycle pulse: that requester's frame's stop bit has completed.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `tx`  out  1  serial line, idle high.
- `tick16`  out  1  one-cycle pulse per 16x tick (debug / RX reuse).

## Operation
- Tick counter `tcnt` counts 0..TICK_DIV-1 and wraps. `tick16` = (`tcnt` == TICK_DIV-1).
- `tcnt` is forced to 0 on the cycle the FSM enters START, so bit boundaries align to frame start.
- Sub-bit counter `scnt` (0..OVERSAMPLE-1) advances on `tick16`. Bit counter `bcnt` (0..DATA_W-1) advances when `scnt` wraps.
- States:
  - IDLE: `tx`=1. On a clock edge with `req`≠0, the arbiter picks a winner and moves to START.
  - START: `tx`=0 for OVERSAMPLE ticks, then DATA.
  - DATA: `tx`=shift[0], LSB first. The shift register shifts right at each bit end. After DATA_W bits, go to STOP.
  - STOP: `tx`=1 for OVERSAMPLE ticks, then IDLE.
- Arbitration:
  - Round-robin pointer `rr` names the preferred requester.
  - If only one `req` bit is set, that requester wins.
  - If both are set, `rr` wins.
  - After a grant, `rr` points to the other requester.
- Grant edge actions: the winner's data is loaded into the shift register, `gnt[winner]` is high for the next cycle only, and the winner ID is stored for `done`.
- `done[id]` pulses for one cycle on the cycle the FSM returns to IDLE.
- `req` is ignored outside IDLE. A `req` that drops before being granted is never served and produces no `gnt`.
- `tx`, `gnt` and `done` are registered outputs, with no combinational path from `req`.

## Timing
- Reset values (immediate, asynchronous):
  - Outputs: `tx`=1, `gnt`=0, `done`=0, `busy`=0, `tick16`=0.
  - Internal: FSM=IDLE, `rr`=0 (requester 0 preferred), all counters 0.
- Reset mid-frame: the frame is aborted, `tx` returns to 1 at once, and no `done` is issued.
- Grant latency: `req` is sampled at edge E. START, `busy`=1, `tx`=0 and `gnt` are all visible after E.
- Bit period: exactly OVERSAMPLE·TICK_DIV = 5216 cycles.
- Frame: 10 bits = 52160 cycles from the START entry edge to the IDLE entry edge. `done` pulses in the first IDLE cycle.
- Back-to-back: if `req` is still high in the first IDLE cycle, the next grant occurs at that edge. The inter-frame gap on `tx` (high) is 1 cycle plus the stop bit.
- Simultaneous requests in IDLE produce strict alternation 0,1,0,1…, starting with 0 after reset.
- `tick16` keeps pulsing in every state, including IDLE.

## Test plan
- Reset: hold `reset_n`=0 for 5 cycles, then release with `req`=0. Required: `tx`=1, `busy`=0, `gnt`=0, `done`=0, and `tick16` pulses every 326 cycles.
- Single frame: `req`=01, `data0`=8'hA5.
  - `gnt`=01 for 1 cycle.
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 5216 cycles long.
  - `done`=01 is seen 52160 cycles after `gnt`.
- Contention: `req`=11 held continuously, `data0`=8'h55, `data1`=8'hAA. Required: 4 frames granted in order 0,1,0,1, with 1-cycle gaps and `done` IDs matching the grant order.
- Withdrawn request: assert `req`=10 during a requester-0 frame and drop it before the frame ends. Required: no `gnt[1]`, and the FSM stays in IDLE afterwards.
- Reset mid-frame: pulse `reset_n` low at data bit 3 of an 8'h00 frame. Required: `tx`=1 within the reset cycle, no `done`, `rr`=0. A following `req`=11 is granted to requester 0.
- Tick alignment: issue `req` at an arbitrary `tcnt` phase, e.g. 200. Required: the start bit still lasts exactly 5216 cycles.
